// File: rtl/fifo_byte_reader.sv
// Purpose : pops words from an upstream FIFO and serialises each one into bytes.
// Latency : a word seen while IDLE becomes byte_valid on the next cycle; words run back-to-back with no bubble.
// Backpress: byte_out/byte_valid hold until byte_ready; no new fetch occurs until the last byte is accepted.
//
// Byte order: least significant byte first by default. Define FIFO_BYTE_READER_MSB_FIRST_EN
// to emit the most significant byte first instead.
// Legal data_width values: multiples of 8 from 8 to 64.

module fifo_byte_reader #(
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_next,
    input  logic                  enable,
    input  logic                  abort,
    output logic [7:0]            byte_out,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic                  busy,
    output logic [15:0]           words_sent
);

    localparam int nbytes = data_width / 8;
    localparam int idx_w  = (nbytes > 1) ? $clog2(nbytes) : 1;
    localparam logic [idx_w-1:0] last_idx = idx_w'(nbytes - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [data_width-1:0] hold_q;
    logic [data_width-1:0] hold_nxt;
    logic [idx_w-1:0]      idx_q;
    logic [idx_w-1:0]      idx_nxt;
    logic [15:0]           words_q;
    logic [15:0]           words_nxt;

    logic accept;
    logic last_accept;
    logic fetch;

    // A byte is offered for every cycle spent in SEND; the state register alone
    // drives these so they collapse to 0 the instant reset rises.
    assign byte_valid  = (state == SEND);
    assign busy        = (state != IDLE);
    assign words_sent  = words_q;

    assign accept      = byte_valid && byte_ready;
    assign last_accept = accept && (idx_q == last_idx);

    // Fetch either from IDLE or in the cycle the final byte leaves, so words
    // chain without a gap. Reset and abort both veto the pop combinationally.
    assign fetch     = !reset && enable && !fifo_empty && !abort &&
                       ((state == IDLE) || last_accept);
    assign fifo_next = fetch;

    // Select the byte under the index from the holding register.
    always_comb begin
        byte_out = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            if (idx_q == idx_w'(i)) begin
`ifdef FIFO_BYTE_READER_MSB_FIRST_EN
                byte_out = hold_q[8*(nbytes-1-i) +: 8];
`else
                byte_out = hold_q[8*i +: 8];
`endif
            end
        end
    end

    // Next-state and datapath update; abort overrides every other event.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_q;
        idx_nxt   = idx_q;
        words_nxt = words_q;
        if (abort) begin
            // Drop the word in flight without counting it.
            state_nxt = IDLE;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch) begin
                        hold_nxt  = fifo_data;
                        idx_nxt   = '0;
                        state_nxt = SEND;
                    end
                end
                SEND: begin
                    if (last_accept) begin
                        words_nxt = words_q + 16'd1;
                        idx_nxt   = '0;
                        if (fetch) begin
                            hold_nxt  = fifo_data;
                            state_nxt = SEND;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else if (accept) begin
                        idx_nxt = idx_q + idx_w'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Holding register, byte index and completed-word counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q  <= '0;
            idx_q   <= '0;
            words_q <= 16'h0000;
        end else begin
            hold_q  <= hold_nxt;
            idx_q   <= idx_nxt;
            words_q <= words_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_byte_reader.sv
// Bench for fifo_byte_reader: a byte-queue reference model checks every cycle of
// the 32-bit instance; an 8-bit instance runs the words_sent wrap-around.
// Build with FIFO_BYTE_READER_MSB_FIRST_EN defined to check the MSB-first order.

module tb_fifo_byte_reader;

    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          fifo_next;
    logic          enable;
    logic          abort;
    logic [7:0]    byte_out;
    logic          byte_valid;
    logic          byte_ready;
    logic          busy;
    logic [15:0]   words_sent;

    logic [7:0]    fifo_data8;
    logic          fifo_empty8;
    logic          fifo_next8;
    logic          en8;
    logic          abort8;
    logic [7:0]    byte_out8;
    logic          byte_valid8;
    logic          ready8;
    logic          busy8;
    logic [15:0]   words8;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_byte_reader #(.data_width(DW)) dut (
        .clk(clk), .reset(reset),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_next(fifo_next),
        .enable(enable), .abort(abort),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .busy(busy), .words_sent(words_sent)
    );

    fifo_byte_reader #(.data_width(8)) dut8 (
        .clk(clk), .reset(reset),
        .fifo_data(fifo_data8), .fifo_empty(fifo_empty8), .fifo_next(fifo_next8),
        .enable(en8), .abort(abort8),
        .byte_out(byte_out8), .byte_valid(byte_valid8), .byte_ready(ready8),
        .busy(busy8), .words_sent(words8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: upstream FIFO contents, bytes still owed for the word in
    // flight, and the number of completed words.
    logic [DW-1:0] fifo_q[$];
    logic [7:0]    cur[$];
    logic [15:0]   m_words;

    // Snapshot of one cycle: {fifo_next, byte_valid, busy, byte_out, words_sent}.
    logic [26:0] exp_vec;
    logic [26:0] obs_vec;
    logic        obs_next;
    logic        obs_valid;
    logic [7:0]  obs_byte;
    logic [15:0] obs_words;

    // Byte n of a word in emission order.
    function automatic logic [7:0] nth_byte(input logic [DW-1:0] w, input int n);
`ifdef FIFO_BYTE_READER_MSB_FIRST_EN
        return w[8*(DW/8-1-n) +: 8];
`else
        return w[8*n +: 8];
`endif
    endfunction

    // One clock: present FIFO head, sample outputs before the edge, advance model.
    task automatic step();
        logic          e_valid;
        logic          e_fetch;
        logic [7:0]    e_byte;
        logic [DW-1:0] w;
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? '0 : fifo_q[0];
        #1;
        e_valid = (cur.size() != 0);
        e_fetch = enable && !fifo_empty && !abort &&
                  (!e_valid || (cur.size() == 1 && byte_ready));
        e_byte  = e_valid ? cur[0] : 8'h00;
        obs_next  = fifo_next;
        obs_valid = byte_valid;
        obs_byte  = byte_out;
        obs_words = words_sent;
        exp_vec = {e_fetch, e_valid, e_valid, e_byte, m_words};
        obs_vec = {fifo_next, byte_valid, busy, (e_valid ? byte_out : 8'h00), words_sent};
        @(posedge clk);
        if (abort) begin
            cur.delete();
        end else begin
            if (e_valid && byte_ready) begin
                void'(cur.pop_front());
                if (cur.size() == 0) m_words = m_words + 16'd1;
            end
            if (e_fetch) begin
                w = fifo_q.pop_front();
                for (int i = 0; i < DW/8; i++) cur.push_back(nth_byte(w, i));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        enable     = 1'b1;
        fifo_empty = 1'b0;
        fifo_data  = 32'hCAFEF00D;
        #1;
        n_tests++; if (fifo_next !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_next got %b want 0", fifo_next); end
        n_tests++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_byte_valid got %b want 0", byte_valid); end
        n_tests++; if (byte_out !== 8'h00) begin n_fail++; $display("FAIL reset_byte_out got %h want 00", byte_out); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (words_sent !== 16'h0000) begin n_fail++; $display("FAIL reset_words_sent got %h want 0000", words_sent); end
        n_tests++; if (words8 !== 16'h0000) begin n_fail++; $display("FAIL reset_words8 got %h want 0000", words8); end
        enable     = 1'b0;
        fifo_empty = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        cur.delete();
        m_words = 16'h0000;
        step();
        n_tests++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL reset_idle got %h want %h", obs_vec, exp_vec); end
    endtask

    task automatic test_single_word();
        logic [7:0] log_b[$];
        int first_acc = -1;
        int last_acc  = -1;
        int nfetch    = 0;
        logic [15:0] w0 = m_words;
        fifo_q.push_back(32'h44332211);
        enable = 1'b1; byte_ready = 1'b1; abort = 1'b0;
        for (int s = 0; s < 7; s++) begin
            step();
            n_tests++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL single c%0d got %h want %h", s, obs_vec, exp_vec); end
            if (obs_next) nfetch++;
            if (obs_valid && byte_ready) begin
                log_b.push_back(obs_byte);
                if (first_acc < 0) first_acc = s;
                last_acc = s;
            end
        end
        n_tests++; if (nfetch != 1) begin n_fail++; $display("FAIL single_fetches got %0d want 1", nfetch); end
        n_tests++; if (log_b.size() != 4) begin n_fail++; $display("FAIL single_nbytes got %0d want 4", log_b.size()); end
        for (int i = 0; i < 4 && i < log_b.size(); i++) begin
            n_tests++; if (log_b[i] !== nth_byte(32'h44332211, i)) begin n_fail++; $display("FAIL single_byte%0d got %h want %h", i, log_b[i], nth_byte(32'h44332211, i)); end
        end
        n_tests++; if (last_acc - first_acc != 3) begin n_fail++; $display("FAIL single_consecutive got span %0d want 3", last_acc - first_acc); end
        n_tests++; if (obs_words !== w0 + 16'd1) begin n_fail++; $display("FAIL single_words got %h want %h", obs_words, w0 + 16'd1); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words[2] = '{32'hA0A1A2A3, 32'hB0B1B2B3};
        logic [7:0] log_b[$];
        int first_acc = -1;
        int last_acc  = -1;
        int nfetch    = 0;
        logic [15:0] w0 = m_words;
        fifo_q.push_back(words[0]);
        fifo_q.push_back(words[1]);
        enable = 1'b1; byte_ready = 1'b1; abort = 1'b0;
        for (int s = 0; s < 11; s++) begin
            step();
            n_tests++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL b2b c%0d got %h want %h", s, obs_vec, exp_vec); end
            if (obs_next) nfetch++;
            if (obs_valid && byte_ready) begin
                log_b.push_back(obs_byte);
                if (first_acc < 0) first_acc = s;
                last_acc = s;
            end
        end
        n_tests++; if (nfetch != 2) begin n_fail++; $display("FAIL b2b_fetches got %0d want 2", nfetch); end
        n_tests++; if (log_b.size() != 8) begin n_fail++; $display("FAIL b2b_nbytes got %0d want 8", log_b.size()); end
        for (int i = 0; i < 8 && i < log_b.size(); i++) begin
            n_tests++; if (log_b[i] !== nth_byte(words[i/4], i%4)) begin n_fail++; $display("FAIL b2b_byte%0d got %h want %h", i, log_b[i], nth_byte(words[i/4], i%4)); end
        end
        n_tests++; if (last_acc - first_acc != 7) begin n_fail++; $display("FAIL b2b_bubble got span %0d want 7", last_acc - first_acc); end
        n_tests++; if (obs_words !== w0 + 16'd2) begin n_fail++; $display("FAIL b2b_words got %h want %h", obs_words, w0 + 16'd2); end
    endtask

    task automatic test_stall();
        int acc    = 0;
        int stall  = 3;
        int nfetch = 0;
        fifo_q.push_back(32'hDEADBEEF);
        enable = 1'b1; abort = 1'b0;
        for (int s = 0; s < 10; s++) begin
            byte_ready = !(acc == 2 && stall > 0);
            step();
            n_tests++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL stall c%0d got %h want %h", s, obs_vec, exp_vec); end
            if (obs_next) nfetch++;
            if (!byte_ready) begin
                stall--;
                n_tests++; if (obs_byte !== nth_byte(32'hDEADBEEF, 2) || obs_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold got %h/%b want %h/1", obs_byte, obs_valid, nth_byte(32'hDEADBEEF, 2)); end
            end
            if (obs_valid && byte_ready) acc++;
        end
        byte_ready = 1'b1;
        n_tests++; if (stall != 0) begin n_fail++; $display("FAIL stall_cycles got %0d left want 0", stall); end
        n_tests++; if (nfetch != 1) begin n_fail++; $display("FAIL stall_fetches got %0d want 1", nfetch); end
    endtask

    task automatic test_abort();
        logic [15:0] w0 = m_words;
        fifo_q.push_back(32'h55667788);
        enable = 1'b1; byte_ready = 1'b1; abort = 1'b0;
        for (int s = 0; s < 4; s++) begin
            abort = (s == 2);
            step();
            n_tests++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL abort c%0d got %h want %h", s, obs_vec, exp_vec); end
            if (s == 2) begin
                n_tests++; if (obs_next !== 1'b0 || obs_byte !== nth_byte(32'h55667788, 1)) begin n_fail++; $display("FAIL abort_cycle got next=%b byte=%h want 0/%h", obs_next, obs_byte, nth_byte(32'h55667788, 1)); end
            end
            if (s == 3) begin
                n_tests++; if (obs_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle got valid=%b busy=%b want 0/0", obs_valid, busy); end
                n_tests++; if (obs_words !== w0) begin n_fail++; $display("FAIL abort_words got %h want %h", obs_words, w0); end
            end
        end
        abort = 1'b0;
    endtask

    task automatic test_enable();
        fifo_q.push_back(32'h0BADF00D);
        enable = 1'b0; byte_ready = 1'b1; abort = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step();
            n_tests++; if (obs_next !== 1'b0 || obs_vec !== exp_vec) begin n_fail++; $display("FAIL enable_off c%0d got %h want %h", s, obs_vec, exp_vec); end
        end
        enable = 1'b1;
        step();
        n_tests++; if (obs_next !== 1'b1) begin n_fail++; $display("FAIL enable_fetch got %b want 1", obs_next); end
        for (int s = 0; s < 5; s++) begin
            step();
            if (s == 0) begin
                n_tests++; if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL enable_valid got %b want 1", obs_valid); end
            end
            n_tests++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL enable_drain c%0d got %h want %h", s, obs_vec, exp_vec); end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 2500; s++) begin
            if (fifo_q.size() < 4 && $urandom_range(0, 2) == 0) fifo_q.push_back($urandom);
            enable     = ($urandom_range(0, 7) != 0);
            byte_ready = ($urandom_range(0, 3) != 0);
            abort      = ($urandom_range(0, 31) == 0);
            step();
            n_tests++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL random c%0d got %h want %h", s, obs_vec, exp_vec); end
        end
        enable = 1'b1; byte_ready = 1'b1; abort = 1'b0;
        for (int s = 0; s < 30; s++) begin
            step();
            n_tests++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL random_drain c%0d got %h want %h", s, obs_vec, exp_vec); end
        end
    endtask

    // 8-bit instance: one word per cycle once running, so 65536 completions wrap the counter.
    task automatic test_wrap();
        fifo_data8 = 8'h5A; fifo_empty8 = 1'b0; ready8 = 1'b1; abort8 = 1'b0;
        en8 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (words8 !== 16'h0001) begin n_fail++; $display("FAIL wrap_first got %h want 0001", words8); end
        repeat (65534) @(posedge clk);
        #1;
        n_tests++; if (words8 !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max got %h want ffff", words8); end
        @(posedge clk);
        #1;
        n_tests++; if (words8 !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero got %h want 0000", words8); end
        n_tests++; if (byte_valid8 !== 1'b1 || byte_out8 !== 8'h5A) begin n_fail++; $display("FAIL wrap_stream got %b/%h want 1/5a", byte_valid8, byte_out8); end
        @(negedge clk);
        en8 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_word();
        fifo_q.push_back(32'h13579BDF);
        fifo_q.push_back(32'h2468ACE0);
        enable = 1'b1; byte_ready = 1'b1; abort = 1'b0;
        for (int s = 0; s < 2; s++) begin
            step();
            n_tests++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL midreset_pre c%0d got %h want %h", s, obs_vec, exp_vec); end
        end
        fifo_empty = 1'b0;
        fifo_data  = fifo_q[0];
        #2;
        reset = 1'b1;
        #1;
        n_tests++; if (fifo_next !== 1'b0) begin n_fail++; $display("FAIL midreset_fifo_next got %b want 0", fifo_next); end
        n_tests++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_byte_valid got %b want 0", byte_valid); end
        n_tests++; if (byte_out !== 8'h00) begin n_fail++; $display("FAIL midreset_byte_out got %h want 00", byte_out); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", busy); end
        n_tests++; if (words_sent !== 16'h0000) begin n_fail++; $display("FAIL midreset_words got %h want 0000", words_sent); end
        @(negedge clk);
        reset   = 1'b0;
        cur.delete();
        m_words = 16'h0000;
        step();
        n_tests++; if (obs_next !== 1'b1) begin n_fail++; $display("FAIL midreset_first_fetch got %b want 1", obs_next); end
        for (int s = 0; s < 6; s++) begin
            step();
            n_tests++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL midreset_post c%0d got %h want %h", s, obs_vec, exp_vec); end
        end
        n_tests++; if (obs_words !== 16'h0001) begin n_fail++; $display("FAIL midreset_count got %h want 0001", obs_words); end
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        abort       = 1'b0;
        byte_ready  = 1'b0;
        fifo_empty  = 1'b1;
        fifo_data   = '0;
        en8         = 1'b0;
        abort8      = 1'b0;
        ready8      = 1'b0;
        fifo_empty8 = 1'b1;
        fifo_data8  = 8'h00;
        m_words     = 16'h0000;

        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_abort();
        test_enable();
        test_random();
        test_wrap();
        test_reset_mid_word();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
